// File: rtl/cpu_core_pkg.sv
// Shared core types for the writeback stage: load opcodes, load-queue entry layout
// and the default load-queue depth.
`ifndef XLEN
`define XLEN 32
`endif

package cpu_core_pkg;

    localparam int LQ_DEPTH_DEF = 2;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_op_e;

    typedef struct packed {
        logic [4:0]        rd;
        logic [2:0]        funct3;
        logic [1:0]        byte_off;
        logic [`XLEN-1:0]  rdata;
    } lq_entry_t;

    function automatic logic is_legal_load(input logic [2:0] funct3);
        return funct3 inside {LB, LH, LW, LBU, LHU};
    endfunction

endpackage

// File: rtl/writeback_unit_if.sv
// Result-collection and register-file-write bundle between EXU/LSU, the
// writeback unit and its consumers.
`ifndef XLEN
`define XLEN 32
`endif

interface writeback_unit_if #(
    parameter int XLEN = `XLEN
);
    logic            exu_valid_i;
    logic            exu_ready_o;
    logic            exu_wen_i;
    logic [4:0]      exu_rd_i;
    logic [XLEN-1:0] exu_result_i;

    logic            lsu_valid_i;
    logic            lsu_ready_o;
    logic [4:0]      lsu_rd_i;
    logic [2:0]      lsu_funct3_i;
    logic [1:0]      lsu_byte_off_i;
    logic [XLEN-1:0] lsu_rdata_i;

    logic            wbu_w_enable_o;
    logic [4:0]      wbu_rd_addr_o;
    logic [XLEN-1:0] wbu_wdata_o;
    logic            wbu_stall_o;
    logic            load_err_o;
    logic [31:0]     retire_count_o;

    // Upstream/consumer side: drives results, observes handshake and writes.
    modport master (
        output exu_valid_i, exu_wen_i, exu_rd_i, exu_result_i,
        output lsu_valid_i, lsu_rd_i, lsu_funct3_i, lsu_byte_off_i, lsu_rdata_i,
        input  exu_ready_o, lsu_ready_o,
        input  wbu_w_enable_o, wbu_rd_addr_o, wbu_wdata_o, wbu_stall_o,
        input  load_err_o, retire_count_o
    );

    modport slave (
        input  exu_valid_i, exu_wen_i, exu_rd_i, exu_result_i,
        input  lsu_valid_i, lsu_rd_i, lsu_funct3_i, lsu_byte_off_i, lsu_rdata_i,
        output exu_ready_o, lsu_ready_o,
        output wbu_w_enable_o, wbu_rd_addr_o, wbu_wdata_o, wbu_stall_o,
        output load_err_o, retire_count_o
    );
endinterface

// File: rtl/writeback_unit_load_data_align.sv
// Extracts and sign/zero-extends the addressed byte or halfword of a raw load word
// and flags load opcodes that do not exist.
`ifndef XLEN
`define XLEN 32
`endif

module load_data_align
    import cpu_core_pkg::*;
#(
    parameter int XLEN = `XLEN
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      byte_off,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data,
    output logic            illegal
);
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Halfword selection uses only off[1]; a misaligned off[0] is ignored.
    assign sel_byte = rdata[{byte_off, 3'b000} +: 8];
    assign sel_half = rdata[{byte_off[1], 4'b0000} +: 16];
    assign illegal  = !is_legal_load(funct3);

    always_comb begin
        data = '0;
        case (funct3)
            LB:      data = {{(XLEN-8){sel_byte[7]}}, sel_byte};
            LBU:     data = {{(XLEN-8){1'b0}}, sel_byte};
            LH:      data = {{(XLEN-16){sel_half[15]}}, sel_half};
            LHU:     data = {{(XLEN-16){1'b0}}, sel_half};
            LW:      data = rdata;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Final pipeline stage: queues returning loads, arbitrates loads over EXU results
// and issues one registered register-file write per cycle plus a retire count.
`ifndef XLEN
`define XLEN 32
`endif

module writeback_unit
    import cpu_core_pkg::*;
#(
    parameter int XLEN     = `XLEN,
    parameter int LQ_DEPTH = LQ_DEPTH_DEF
) (
    input logic             clock_i,
    input logic             reset_i,
    writeback_unit_if.slave bus
);
    localparam int          PW        = $clog2(LQ_DEPTH);
    localparam logic [PW:0] DEPTH_CNT = (PW+1)'(LQ_DEPTH);

    lq_entry_t        queue [LQ_DEPTH];
    lq_entry_t        head_entry;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW:0]      count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             exu_take;
    logic             commit;

    logic [XLEN-1:0]  load_data;
    logic             load_illegal;

    logic             w_enable;
    logic [4:0]       rd_addr;
    logic [XLEN-1:0]  wdata;
    logic             load_err;
    logic [31:0]      retire_count;
    logic             next_w_enable;
    logic [4:0]       next_rd_addr;
    logic [XLEN-1:0]  next_wdata;
    logic             next_load_err;

    // Queued loads always win; the EXU only gets the port when no load is waiting.
    assign full       = (count == DEPTH_CNT);
    assign empty      = (count == '0);
    assign push       = bus.lsu_valid_i && !full;
    assign pop        = !empty;
    assign exu_take   = empty && bus.exu_valid_i;
    assign commit     = pop || exu_take;
    assign head_entry = queue[head];

    load_data_align #(
        .XLEN (XLEN)
    ) u_align (
        .funct3   (head_entry.funct3),
        .byte_off (head_entry.byte_off),
        .rdata    (head_entry.rdata),
        .data     (load_data),
        .illegal  (load_illegal)
    );

    always_ff @(posedge clock_i) begin
        if (push) begin
            queue[tail] <= '{rd:       bus.lsu_rd_i,
                             funct3:   bus.lsu_funct3_i,
                             byte_off: bus.lsu_byte_off_i,
                             rdata:    bus.lsu_rdata_i};
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Address and data latch on every commit, even when the enable ends up low.
    always_comb begin
        next_w_enable = 1'b0;
        next_rd_addr  = rd_addr;
        next_wdata    = wdata;
        next_load_err = 1'b0;
        if (pop) begin
            next_rd_addr  = head_entry.rd;
            next_wdata    = load_illegal ? '0 : load_data;
            next_w_enable = !load_illegal && (head_entry.rd != 5'd0);
            next_load_err = load_illegal;
        end else if (exu_take) begin
            next_rd_addr  = bus.exu_rd_i;
            next_wdata    = bus.exu_result_i;
            next_w_enable = bus.exu_wen_i && (bus.exu_rd_i != 5'd0);
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            w_enable     <= 1'b0;
            rd_addr      <= '0;
            wdata        <= '0;
            load_err     <= 1'b0;
            retire_count <= '0;
        end else begin
            w_enable <= next_w_enable;
            rd_addr  <= next_rd_addr;
            wdata    <= next_wdata;
            load_err <= next_load_err;
            if (commit) retire_count <= retire_count + 32'd1;
        end
    end

    assign bus.exu_ready_o    = empty;
    assign bus.lsu_ready_o    = !full;
    assign bus.wbu_stall_o    = full;
    assign bus.wbu_w_enable_o = w_enable;
    assign bus.wbu_rd_addr_o  = rd_addr;
    assign bus.wbu_wdata_o    = wdata;
    assign bus.load_err_o     = load_err;
    assign bus.retire_count_o = retire_count;

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: randomized EXU/LSU traffic compared
// against a queue-based model of commit order, load extraction and retire count.
`timescale 1ns/1ps

module tb_writeback_unit;
    import cpu_core_pkg::*;

    localparam int D = LQ_DEPTH_DEF;

    logic clock;
    logic reset;
    int   vectors;
    int   miscompares;

    writeback_unit_if #(.XLEN(32)) bus ();

    writeback_unit #(
        .XLEN     (32),
        .LQ_DEPTH (D)
    ) dut (
        .clock_i (clock),
        .reset_i (reset),
        .bus     (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model state: pending loads in arrival order plus the expected write port.
    lq_entry_t   model_q[$];
    logic        m_en;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        m_err;
    logic [31:0] m_retire;
    bit          exu_taken;

    function automatic void ref_load(input lq_entry_t e, output logic [31:0] d, output bit ill);
        logic [7:0]         b;
        logic [15:0]        h;
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        b   = 8'(e.rdata >> (8 * e.byte_off));
        h   = 16'(e.rdata >> (16 * e.byte_off[1]));
        sb  = b;
        sh  = h;
        ill = 1'b0;
        case (e.funct3)
            3'b000:  d = 32'(sb);
            3'b100:  d = 32'(b);
            3'b001:  d = 32'(sh);
            3'b101:  d = 32'(h);
            3'b010:  d = e.rdata;
            default: begin d = 32'd0; ill = 1'b1; end
        endcase
    endfunction

    function automatic logic [2:0] rand_legal_f3();
        logic [2:0] tab [5];
        tab[0] = 3'b000; tab[1] = 3'b001; tab[2] = 3'b010; tab[3] = 3'b100; tab[4] = 3'b101;
        return tab[$urandom_range(0, 4)];
    endfunction

    task automatic apply_exu(input logic v, input logic w, input logic [4:0] rd, input logic [31:0] res);
        bus.exu_valid_i  = v;
        bus.exu_wen_i    = w;
        bus.exu_rd_i     = rd;
        bus.exu_result_i = res;
    endtask

    task automatic apply_load(input logic v, input logic [4:0] rd, input logic [2:0] f3,
                              input logic [1:0] off, input logic [31:0] data);
        bus.lsu_valid_i    = v;
        bus.lsu_rd_i       = rd;
        bus.lsu_funct3_i   = f3;
        bus.lsu_byte_off_i = off;
        bus.lsu_rdata_i    = data;
    endtask

    // Advance one edge: predict the commit from the current inputs, then sample #1 after.
    task automatic tick();
        lq_entry_t   e;
        lq_entry_t   n;
        logic [31:0] d;
        bit          ill;
        bit          push;
        push      = bus.lsu_valid_i && (model_q.size() < D);
        exu_taken = 1'b0;
        m_en      = 1'b0;
        m_err     = 1'b0;
        if (model_q.size() > 0) begin
            e = model_q.pop_front();
            ref_load(e, d, ill);
            m_addr   = e.rd;
            m_data   = d;
            m_en     = !ill && (e.rd != 5'd0);
            m_err    = ill;
            m_retire = m_retire + 32'd1;
        end else if (bus.exu_valid_i) begin
            exu_taken = 1'b1;
            m_addr    = bus.exu_rd_i;
            m_data    = bus.exu_result_i;
            m_en      = bus.exu_wen_i && (bus.exu_rd_i != 5'd0);
            m_retire  = m_retire + 32'd1;
        end
        if (push) begin
            n.rd       = bus.lsu_rd_i;
            n.funct3   = bus.lsu_funct3_i;
            n.byte_off = bus.lsu_byte_off_i;
            n.rdata    = bus.lsu_rdata_i;
            model_q.push_back(n);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        model_q.delete();
        m_en      = 1'b0;
        m_addr    = 5'd0;
        m_data    = 32'd0;
        m_err     = 1'b0;
        m_retire  = 32'd0;
        exu_taken = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        apply_exu(0, 0, 5'd0, 32'd0);
        apply_load(0, 5'd0, 3'b000, 2'd0, 32'd0);
        model_reset();
        #3;
        vectors++;
        if ({bus.wbu_w_enable_o, bus.wbu_rd_addr_o, bus.wbu_wdata_o, bus.load_err_o, bus.retire_count_o} !== 71'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got en=%b rd=%0d data=%h err=%b ret=%0d, want all zero",
                     bus.wbu_w_enable_o, bus.wbu_rd_addr_o, bus.wbu_wdata_o, bus.load_err_o, bus.retire_count_o);
        end
        vectors++;
        if ({bus.lsu_ready_o, bus.wbu_stall_o, bus.exu_ready_o} !== 3'b101) begin
            miscompares++;
            $display("[TB] FAIL reset_handshake: got lsu_ready=%b stall=%b exu_ready=%b, want 1 0 1",
                     bus.lsu_ready_o, bus.wbu_stall_o, bus.exu_ready_o);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_exu_only();
        apply_exu(1, 1, 5'd5, 32'h1234_5678);
        tick();
        apply_exu(0, 0, 5'd0, 32'd0);
        vectors++;
        if ({bus.wbu_w_enable_o, bus.wbu_rd_addr_o, bus.wbu_wdata_o, bus.retire_count_o} !== {1'b1, 5'd5, 32'h1234_5678, 32'd1}) begin
            miscompares++;
            $display("[TB] FAIL exu_first: got en=%b rd=%0d data=%h ret=%0d, want en=1 rd=5 data=12345678 ret=1",
                     bus.wbu_w_enable_o, bus.wbu_rd_addr_o, bus.wbu_wdata_o, bus.retire_count_o);
        end
        tick();
        for (int i = 0; i < 6; i++) begin
            apply_exu($urandom_range(0, 3) != 0, 1'($urandom), 5'($urandom), $urandom);
            tick();
            vectors++;
            if ({bus.wbu_w_enable_o, bus.wbu_rd_addr_o, bus.wbu_wdata_o, bus.load_err_o, bus.retire_count_o} !== {m_en, m_addr, m_data, m_err, m_retire}) begin
                miscompares++;
                $display("[TB] FAIL exu_random: got en=%b rd=%0d data=%h err=%b ret=%0d, want en=%b rd=%0d data=%h err=%b ret=%0d",
                         bus.wbu_w_enable_o, bus.wbu_rd_addr_o, bus.wbu_wdata_o, bus.load_err_o, bus.retire_count_o,
                         m_en, m_addr, m_data, m_err, m_retire);
            end
        end
        apply_exu(0, 0, 5'd0, 32'd0);
        tick();
    endtask

    task automatic test_load_extract();
        logic [2:0]  f3s  [5];
        logic [1:0]  offs [5];
        logic [31:0] exps [5];
        f3s[0] = 3'b000; offs[0] = 2'd3; exps[0] = 32'hFFFF_FF80;
        f3s[1] = 3'b100; offs[1] = 2'd3; exps[1] = 32'h0000_0080;
        f3s[2] = 3'b001; offs[2] = 2'd2; exps[2] = 32'hFFFF_80FF;
        f3s[3] = 3'b101; offs[3] = 2'd2; exps[3] = 32'h0000_80FF;
        f3s[4] = 3'b010; offs[4] = 2'd3; exps[4] = 32'h80FF_7F01;
        for (int i = 0; i < 5; i++) begin
            apply_load(1, 5'(10 + i), f3s[i], offs[i], 32'h80FF_7F01);
            tick();
            apply_load(0, 5'd0, 3'b000, 2'd0, 32'd0);
            tick();
            vectors++;
            if ({bus.wbu_w_enable_o, bus.wbu_rd_addr_o, bus.wbu_wdata_o, bus.load_err_o} !== {1'b1, 5'(10 + i), exps[i], 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL load_table[%0d]: got en=%b rd=%0d data=%h err=%b, want en=1 rd=%0d data=%h err=0",
                         i, bus.wbu_w_enable_o, bus.wbu_rd_addr_o, bus.wbu_wdata_o, bus.load_err_o, 10 + i, exps[i]);
            end
        end
        for (int i = 0; i < 12; i++) begin
            apply_load($urandom_range(0, 2) != 0, 5'($urandom), 3'($urandom), 2'($urandom), $urandom);
            tick();
            vectors++;
            if ({bus.wbu_w_enable_o, bus.wbu_rd_addr_o, bus.wbu_wdata_o, bus.load_err_o, bus.retire_count_o} !== {m_en, m_addr, m_data, m_err, m_retire}) begin
                miscompares++;
                $display("[TB] FAIL load_random: got en=%b rd=%0d data=%h err=%b ret=%0d, want en=%b rd=%0d data=%h err=%b ret=%0d",
                         bus.wbu_w_enable_o, bus.wbu_rd_addr_o, bus.wbu_wdata_o, bus.load_err_o, bus.retire_count_o,
                         m_en, m_addr, m_data, m_err, m_retire);
            end
        end
        apply_load(0, 5'd0, 3'b000, 2'd0, 32'd0);
        tick();
        tick();
    endtask

    task automatic test_rd0_illegal();
        logic [31:0] ret_before;
        ret_before = m_retire;
        apply_exu(1, 1, 5'd0, 32'hDEAD_BEEF);
        tick();
        apply_exu(0, 0, 5'd0, 32'd0);
        vectors++;
        if ({bus.wbu_w_enable_o, bus.wbu_rd_addr_o, bus.wbu_wdata_o, bus.retire_count_o} !== {1'b0, 5'd0, 32'hDEAD_BEEF, ret_before + 32'd1}) begin
            miscompares++;
            $display("[TB] FAIL exu_rd0: got en=%b rd=%0d data=%h ret=%0d, want en=0 rd=0 data=deadbeef ret=%0d",
                     bus.wbu_w_enable_o, bus.wbu_rd_addr_o, bus.wbu_wdata_o, bus.retire_count_o, ret_before + 32'd1);
        end
        apply_load(1, 5'd9, 3'b011, 2'd1, 32'hCAFE_F00D);
        tick();
        apply_load(0, 5'd0, 3'b000, 2'd0, 32'd0);
        tick();
        vectors++;
        if ({bus.wbu_w_enable_o, bus.wbu_wdata_o, bus.load_err_o, bus.retire_count_o} !== {1'b0, 32'd0, 1'b1, ret_before + 32'd2}) begin
            miscompares++;
            $display("[TB] FAIL illegal_load: got en=%b data=%h err=%b ret=%0d, want en=0 data=0 err=1 ret=%0d",
                     bus.wbu_w_enable_o, bus.wbu_wdata_o, bus.load_err_o, bus.retire_count_o, ret_before + 32'd2);
        end
        tick();
        vectors++;
        if (bus.load_err_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL load_err_pulse: got err=%b one cycle later, want 0", bus.load_err_o);
        end
    endtask

    task automatic test_back_to_back();
        apply_load(1, 5'($urandom_range(1, 31)), rand_legal_f3(), 2'($urandom), $urandom);
        tick();
        apply_exu(1, 1, 5'd17, 32'hC0FF_EE00);
        for (int c = 0; c < 7; c++) begin
            if (c < 4) apply_load(1, 5'($urandom_range(1, 31)), rand_legal_f3(), 2'($urandom), $urandom);
            else       apply_load(0, 5'd0, 3'b000, 2'd0, 32'd0);
            vectors++;
            if ({bus.lsu_ready_o, bus.wbu_stall_o, bus.exu_ready_o} !== {model_q.size() < D, model_q.size() == D, model_q.size() == 0}) begin
                miscompares++;
                $display("[TB] FAIL contention_handshake[%0d]: got lsu_ready=%b stall=%b exu_ready=%b, want queue depth %0d",
                         c, bus.lsu_ready_o, bus.wbu_stall_o, bus.exu_ready_o, model_q.size());
            end
            tick();
            if (exu_taken) apply_exu(0, 0, 5'd0, 32'd0);
            vectors++;
            if ({bus.wbu_w_enable_o, bus.wbu_rd_addr_o, bus.wbu_wdata_o, bus.load_err_o, bus.retire_count_o} !== {m_en, m_addr, m_data, m_err, m_retire}) begin
                miscompares++;
                $display("[TB] FAIL contention_commit[%0d]: got en=%b rd=%0d data=%h err=%b ret=%0d, want en=%b rd=%0d data=%h err=%b ret=%0d",
                         c, bus.wbu_w_enable_o, bus.wbu_rd_addr_o, bus.wbu_wdata_o, bus.load_err_o, bus.retire_count_o,
                         m_en, m_addr, m_data, m_err, m_retire);
            end
        end
        apply_exu(0, 0, 5'd0, 32'd0);
    endtask

    task automatic test_random_mix();
        for (int i = 0; i < 40; i++) begin
            if (!bus.exu_valid_i || exu_taken) begin
                if ($urandom_range(0, 1) == 1) apply_exu(1, 1'($urandom), 5'($urandom), $urandom);
                else                           apply_exu(0, 0, 5'd0, 32'd0);
            end
            apply_load($urandom_range(0, 1) == 1, 5'($urandom), 3'($urandom), 2'($urandom), $urandom);
            tick();
            vectors++;
            if ({bus.wbu_w_enable_o, bus.wbu_rd_addr_o, bus.wbu_wdata_o, bus.load_err_o, bus.retire_count_o,
                 bus.lsu_ready_o, bus.exu_ready_o} !==
                {m_en, m_addr, m_data, m_err, m_retire, model_q.size() < D, model_q.size() == 0}) begin
                miscompares++;
                $display("[TB] FAIL random_mix[%0d]: got en=%b rd=%0d data=%h err=%b ret=%0d lr=%b er=%b, want en=%b rd=%0d data=%h err=%b ret=%0d depth=%0d",
                         i, bus.wbu_w_enable_o, bus.wbu_rd_addr_o, bus.wbu_wdata_o, bus.load_err_o, bus.retire_count_o,
                         bus.lsu_ready_o, bus.exu_ready_o, m_en, m_addr, m_data, m_err, m_retire, model_q.size());
            end
        end
        apply_exu(0, 0, 5'd0, 32'd0);
        apply_load(0, 5'd0, 3'b000, 2'd0, 32'd0);
        tick();
        tick();
    endtask

    task automatic test_reset_midop();
        apply_exu(1, 1, 5'd3, 32'hA5A5_A5A5);
        apply_load(1, 5'd4, 3'b010, 2'd0, 32'h1122_3344);
        tick();
        apply_exu(0, 0, 5'd0, 32'd0);
        apply_load(0, 5'd0, 3'b000, 2'd0, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if ({bus.wbu_w_enable_o, bus.wbu_rd_addr_o, bus.wbu_wdata_o, bus.load_err_o, bus.retire_count_o} !== 71'd0) begin
            miscompares++;
            $display("[TB] FAIL midop_reset_outputs: got en=%b rd=%0d data=%h err=%b ret=%0d, want all zero",
                     bus.wbu_w_enable_o, bus.wbu_rd_addr_o, bus.wbu_wdata_o, bus.load_err_o, bus.retire_count_o);
        end
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        for (int c = 0; c < 2; c++) begin
            tick();
            vectors++;
            if ({bus.wbu_w_enable_o, bus.wbu_rd_addr_o, bus.wbu_wdata_o, bus.retire_count_o,
                 bus.lsu_ready_o, bus.exu_ready_o} !== {1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1}) begin
                miscompares++;
                $display("[TB] FAIL midop_after_release[%0d]: got en=%b rd=%0d data=%h ret=%0d lr=%b er=%b, want en=0 rd=0 data=0 ret=0 lr=1 er=1",
                         c, bus.wbu_w_enable_o, bus.wbu_rd_addr_o, bus.wbu_wdata_o, bus.retire_count_o,
                         bus.lsu_ready_o, bus.exu_ready_o);
            end
        end
    endtask

    task automatic test_counter_wrap();
        force dut.retire_count = 32'hFFFF_FFFE;
        #1;
        release dut.retire_count;
        m_retire = 32'hFFFF_FFFE;
        vectors++;
        if (bus.retire_count_o !== 32'hFFFF_FFFE) begin
            miscompares++;
            $display("[TB] FAIL wrap_preload: got ret=%h, want fffffffe", bus.retire_count_o);
        end
        for (int i = 0; i < 3; i++) begin
            apply_exu(1, 1, 5'(20 + i), $urandom);
            tick();
            vectors++;
            if ({bus.wbu_w_enable_o, bus.wbu_rd_addr_o, bus.wbu_wdata_o, bus.retire_count_o} !== {m_en, m_addr, m_data, m_retire}) begin
                miscompares++;
                $display("[TB] FAIL wrap_commit[%0d]: got en=%b rd=%0d data=%h ret=%h, want en=%b rd=%0d data=%h ret=%h",
                         i, bus.wbu_w_enable_o, bus.wbu_rd_addr_o, bus.wbu_wdata_o, bus.retire_count_o,
                         m_en, m_addr, m_data, m_retire);
            end
        end
        apply_exu(0, 0, 5'd0, 32'd0);
        vectors++;
        if (bus.retire_count_o !== 32'd1) begin
            miscompares++;
            $display("[TB] FAIL wrap_final: got ret=%h, want 00000001", bus.retire_count_o);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_exu_only();
        test_load_extract();
        test_rd0_illegal();
        test_back_to_back();
        test_random_mix();
        test_reset_midop();
        test_counter_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
